// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX bypass select and ID stall generation with long-latency scoreboard
module fwd_hazard_unit #(
  parameter int NUM_SRC = 3,
  parameter int MAX_LAT = 31,
  parameter int LAT_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ID_valid,
  input  logic [5*NUM_SRC-1:0]   ID_rs,
  input  logic [NUM_SRC-1:0]     ID_rs_fp,
  input  logic [4:0]             ID_rd,
  input  logic                   ID_wr_int,
  input  logic                   ID_wr_fp,
  input  logic [5*NUM_SRC-1:0]   EX_rs,
  input  logic [NUM_SRC-1:0]     EX_rs_fp,
  input  logic [4:0]             EX_rd,
  input  logic                   EX_is_load,
  input  logic                   EX_load_fp,
  input  logic [4:0]             MEM_rd,
  input  logic                   MEM_reg_wr_en,
  input  logic                   MEM_freg_wr_en,
  input  logic [4:0]             WB_rd,
  input  logic                   WB_reg_wr_en,
  input  logic                   WB_freg_wr_en,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  input  logic                   issue_fp,
  input  logic [LAT_W-1:0]       issue_lat,
  output logic [2*NUM_SRC-1:0]   EX_fwd_sel,
  output logic                   stall,
  output logic [31:0]            sb_busy_int,
  output logic [31:0]            sb_busy_fp
);

  // Per-register countdowns: nonzero means a long op result is still outstanding.
  logic [LAT_W-1:0] cnt_int_q [32];
  logic [LAT_W-1:0] cnt_int_d [32];
  logic [LAT_W-1:0] cnt_fp_q  [32];
  logic [LAT_W-1:0] cnt_fp_d  [32];

  logic load_use;
  logic raw_hit;
  logic waw_hit;

  // Bypass choice for one EX source; int x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_pick(input logic [4:0] rs, input logic fp);
    logic mem_hit;
    logic wb_hit;
    mem_hit = (fp ? MEM_freg_wr_en : MEM_reg_wr_en) && (MEM_rd == rs);
    wb_hit  = (fp ? WB_freg_wr_en  : WB_reg_wr_en)  && (WB_rd  == rs);
    if (!fp && rs == 5'd0) begin
      return 2'b00;
    end else if (mem_hit) begin
      return 2'b01;
    end else if (wb_hit) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  // EX operand mux selects, MEM preferred over WB.
  always_comb begin
    EX_fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      EX_fwd_sel[2*i +: 2] = fwd_pick(EX_rs[5*i +: 5], EX_rs_fp[i]);
    end
  end

  // Hazard detection: load-use against EX, RAW/WAW against the scoreboard.
  always_comb begin
    load_use = 1'b0;
    raw_hit  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (EX_is_load && (EX_rd == ID_rs[5*i +: 5]) && (ID_rs_fp[i] == EX_load_fp) &&
          (EX_load_fp || EX_rd != 5'd0)) begin
        load_use = 1'b1;
      end
      if (ID_rs_fp[i] ? (cnt_fp_q[ID_rs[5*i +: 5]] != '0)
                      : (cnt_int_q[ID_rs[5*i +: 5]] != '0)) begin
        raw_hit = 1'b1;
      end
    end
    waw_hit = (ID_wr_int && cnt_int_q[ID_rd] != '0) ||
              (ID_wr_fp  && cnt_fp_q[ID_rd]  != '0);
    stall = ID_valid && (load_use || raw_hit || waw_hit);
  end

  // Scoreboard next state: saturating decrement, a new issue overrides its entry.
  always_comb begin
    for (int k = 0; k < 32; k++) begin
      cnt_int_d[k] = (cnt_int_q[k] == '0) ? '0 : cnt_int_q[k] - LAT_W'(1);
      cnt_fp_d[k]  = (cnt_fp_q[k]  == '0) ? '0 : cnt_fp_q[k]  - LAT_W'(1);
    end
    if (issue_valid) begin
      if (issue_fp) begin
        cnt_fp_d[issue_rd] = issue_lat;
      end else if (issue_rd != 5'd0) begin
        cnt_int_d[issue_rd] = issue_lat;
      end
    end
  end

  // Scoreboard registers; reset clears any countdown in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) begin
        cnt_int_q[k] <= '0;
        cnt_fp_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 32; k++) begin
        cnt_int_q[k] <= cnt_int_d[k];
        cnt_fp_q[k]  <= cnt_fp_d[k];
      end
    end
  end

  // Busy flags straight from the counters.
  always_comb begin
    for (int k = 0; k < 32; k++) begin
      sb_busy_int[k] = (cnt_int_q[k] != '0);
      sb_busy_fp[k]  = (cnt_fp_q[k]  != '0);
    end
  end

  // A zero or out-of-range latency would let a dependent op read a stale value.
  always @(posedge clk) begin
    if (rst_n && issue_valid) begin
      assert (issue_lat != '0 && issue_lat <= LAT_W'(MAX_LAT));
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - randomized bench for fwd_hazard_unit against a ready-time model
module tb_fwd_hazard_unit;
  localparam int NUM_SRC = 3;
  localparam int MAX_LAT = 31;
  localparam int LAT_W   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 ID_valid;
  logic [5*NUM_SRC-1:0] ID_rs;
  logic [NUM_SRC-1:0]   ID_rs_fp;
  logic [4:0]           ID_rd;
  logic                 ID_wr_int, ID_wr_fp;
  logic [5*NUM_SRC-1:0] EX_rs;
  logic [NUM_SRC-1:0]   EX_rs_fp;
  logic [4:0]           EX_rd;
  logic                 EX_is_load, EX_load_fp;
  logic [4:0]           MEM_rd;
  logic                 MEM_reg_wr_en, MEM_freg_wr_en;
  logic [4:0]           WB_rd;
  logic                 WB_reg_wr_en, WB_freg_wr_en;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic                 issue_fp;
  logic [LAT_W-1:0]     issue_lat;
  logic [2*NUM_SRC-1:0] EX_fwd_sel;
  logic                 stall;
  logic [31:0]          sb_busy_int, sb_busy_fp;

  fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rs_fp(ID_rs_fp), .ID_rd(ID_rd),
    .ID_wr_int(ID_wr_int), .ID_wr_fp(ID_wr_fp),
    .EX_rs(EX_rs), .EX_rs_fp(EX_rs_fp), .EX_rd(EX_rd),
    .EX_is_load(EX_is_load), .EX_load_fp(EX_load_fp),
    .MEM_rd(MEM_rd), .MEM_reg_wr_en(MEM_reg_wr_en), .MEM_freg_wr_en(MEM_freg_wr_en),
    .WB_rd(WB_rd), .WB_reg_wr_en(WB_reg_wr_en), .WB_freg_wr_en(WB_freg_wr_en),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_fp(issue_fp), .issue_lat(issue_lat),
    .EX_fwd_sel(EX_fwd_sel), .stall(stall), .sb_busy_int(sb_busy_int), .sb_busy_fp(sb_busy_fp)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: each register remembers the edge number at which its result is written.
  int edge_count = 0;
  int done_int [32];
  int done_fp  [32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic busy(input logic fp, input logic [4:0] r);
    return fp ? (edge_count < done_fp[r]) : (edge_count < done_int[r]);
  endfunction

  function automatic logic [31:0] exp_busy(input logic fp);
    logic [31:0] v;
    for (int k = 0; k < 32; k++) v[k] = busy(fp, 5'(k));
    return v;
  endfunction

  function automatic logic [31:0] exp_fwd();
    logic [31:0] v;
    logic [4:0]  r;
    logic        fp;
    v = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      r  = EX_rs[5*i +: 5];
      fp = EX_rs_fp[i];
      if (fp || r != 0) begin
        if ((fp ? MEM_freg_wr_en : MEM_reg_wr_en) && MEM_rd == r)     v[2*i +: 2] = 2'd1;
        else if ((fp ? WB_freg_wr_en : WB_reg_wr_en) && WB_rd == r)   v[2*i +: 2] = 2'd2;
      end
    end
    return v;
  endfunction

  function automatic logic exp_stall();
    logic s;
    logic [4:0] r;
    s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      r = ID_rs[5*i +: 5];
      if (EX_is_load && EX_rd == r && ID_rs_fp[i] == EX_load_fp && !(!EX_load_fp && r == 0)) s = 1'b1;
      if (busy(ID_rs_fp[i], r)) s = 1'b1;
    end
    if (ID_wr_int && busy(1'b0, ID_rd)) s = 1'b1;
    if (ID_wr_fp  && busy(1'b1, ID_rd)) s = 1'b1;
    return ID_valid && s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      done_int[k] = 0;
      done_fp[k]  = 0;
    end
  endtask

  task automatic model_edge();
    edge_count++;
    if (rst_n && issue_valid) begin
      if (issue_fp) done_fp[issue_rd] = edge_count + int'(issue_lat);
      else if (issue_rd != 0) done_int[issue_rd] = edge_count + int'(issue_lat);
    end
  endtask

  task automatic check_all();
    check_eq("fwd_sel", 32'(EX_fwd_sel), exp_fwd());
    check_eq("stall", 32'(stall), 32'(exp_stall()));
    check_eq("busy_int", sb_busy_int, exp_busy(1'b0));
    check_eq("busy_fp", sb_busy_fp, exp_busy(1'b1));
  endtask

  // Called at a falling edge with inputs settled: check, clock once, return at next falling edge.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ID_valid = 0; ID_rs = '0; ID_rs_fp = '0; ID_rd = '0; ID_wr_int = 0; ID_wr_fp = 0;
    EX_rs = '0; EX_rs_fp = '0; EX_rd = '0; EX_is_load = 0; EX_load_fp = 0;
    MEM_rd = '0; MEM_reg_wr_en = 0; MEM_freg_wr_en = 0;
    WB_rd = '0; WB_reg_wr_en = 0; WB_freg_wr_en = 0;
    issue_valid = 0; issue_rd = '0; issue_fp = 0; issue_lat = '0;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 4));
  endfunction

  task automatic randomize_inputs();
    ID_valid = ($urandom_range(0, 7) != 0);
    for (int i = 0; i < NUM_SRC; i++) begin
      ID_rs[5*i +: 5] = pick();
      EX_rs[5*i +: 5] = pick();
    end
    ID_rs_fp = NUM_SRC'($urandom);
    EX_rs_fp = NUM_SRC'($urandom);
    ID_rd = pick(); ID_wr_int = 1'($urandom); ID_wr_fp = 1'($urandom);
    EX_rd = pick(); EX_is_load = 1'($urandom); EX_load_fp = 1'($urandom);
    MEM_rd = pick(); MEM_reg_wr_en = 1'($urandom); MEM_freg_wr_en = 1'($urandom);
    WB_rd = pick(); WB_reg_wr_en = 1'($urandom); WB_freg_wr_en = 1'($urandom);
    issue_valid = ($urandom_range(0, 3) == 0);
    issue_rd = pick(); issue_fp = 1'($urandom);
    issue_lat = ($urandom_range(0, 9) == 0) ? LAT_W'(MAX_LAT) : LAT_W'($urandom_range(1, 6));
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 0;
    @(negedge clk);
    step();
    check_eq("rst_busy_int", sb_busy_int, 32'd0);
    check_eq("rst_busy_fp", sb_busy_fp, 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    rst_n = 1;

    // MEM beats WB; WB alone forwards.
    MEM_rd = 5; MEM_reg_wr_en = 1; WB_rd = 5; WB_reg_wr_en = 1; EX_rs[4:0] = 5;
    #1 check_eq("t1_mem", 32'(EX_fwd_sel[1:0]), 32'd1);
    MEM_reg_wr_en = 0;
    #1 check_eq("t1_wb", 32'(EX_fwd_sel[1:0]), 32'd2);
    // x0 never forwards, f0 does.
    clear_inputs();
    MEM_rd = 0; MEM_reg_wr_en = 1; EX_rs[9:5] = 0;
    #1 check_eq("t2_x0", 32'(EX_fwd_sel[3:2]), 32'd0);
    MEM_reg_wr_en = 0; MEM_freg_wr_en = 1; EX_rs_fp[1] = 1;
    #1 check_eq("t2_f0", 32'(EX_fwd_sel[3:2]), 32'd1);
    // Load-use only within the same file.
    clear_inputs();
    EX_is_load = 1; EX_rd = 7; ID_rs[14:10] = 7; ID_valid = 1;
    #1 check_eq("t3_lu_int", 32'(stall), 32'd1);
    ID_rs_fp[2] = 1;
    #1 check_eq("t3_lu_fp", 32'(stall), 32'd0);
    @(negedge clk);

    // f3 latency 4: RAW stall for exactly 4 cycles.
    clear_inputs();
    issue_valid = 1; issue_rd = 3; issue_fp = 1; issue_lat = 4;
    step();
    clear_inputs();
    ID_valid = 1; ID_rs[4:0] = 3; ID_rs_fp[0] = 1;
    for (int k = 0; k < 4; k++) begin
      #1 check_eq("t4_stall_on", 32'(stall), 32'd1);
      step();
    end
    #1 check_eq("t4_stall_off", 32'(stall), 32'd0);
    ID_rs_fp[0] = 0;
    step();

    // f1 latency 20, reset asynchronously with 11 cycles left.
    clear_inputs();
    issue_valid = 1; issue_rd = 1; issue_fp = 1; issue_lat = 20;
    step();
    clear_inputs();
    ID_valid = 1; ID_rs[4:0] = 1; ID_rs_fp[0] = 1;
    for (int k = 0; k < 9; k++) step();
    check_eq("t6_busy_pre", sb_busy_fp, 32'h2);
    rst_n = 0;
    model_reset();
    #1 check_eq("t6_busy_rst", sb_busy_fp, 32'd0);
    check_eq("t6_stall_rst", 32'(stall), 32'd0);
    #1 rst_n = 1;
    step();
    // Issue to x0 is ignored.
    clear_inputs();
    issue_valid = 1; issue_rd = 0; issue_fp = 0; issue_lat = 5;
    step();
    check_eq("t6_x0_issue", sb_busy_int, 32'd0);

    // Random traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 2000; n++) begin
      randomize_inputs();
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 0;
        model_reset();
        #1 check_all();
        #1 rst_n = 1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
